// File: rtl/seg_pkg.sv
// Shared constants and types for the scanned 2-digit display receiver.
// Optional feature macro: SEG_ALT_GLYPH_EN (alternate 6/9 glyphs, used by seg_glyph_dec).
package seg_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned SEL_W   = 8;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned VALUE_W = 7;
    localparam int unsigned CNT_W   = 8;

    // Segment glyphs, gfe_dcba active-high
    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3f;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5b;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4f;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6d;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7c;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7f;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h67;

    // Alternate renderings of 6 and 9 (tail segment lit)
    localparam logic [SEG_W-1:0] GLYPH_ALT_6 = 7'h7d;
    localparam logic [SEG_W-1:0] GLYPH_ALT_9 = 7'h6f;

    // Digit-select codes, active-low
    localparam logic [SEL_W-1:0] SEL_TENS  = 8'b0111_1111;
    localparam logic [SEL_W-1:0] SEL_ONES  = 8'b1101_1111;
    localparam logic [SEL_W-1:0] SEL_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        WAIT_TENS = 2'd0,
        WAIT_ONES = 2'd1,
        EMIT      = 2'd2
    } scan_state_e;

    // One synchronized sample of the scan bus
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [SEG_W-1:0] seg;
    } scan_sample_t;

    localparam scan_sample_t SAMPLE_RST = '{sel: SEL_BLANK, seg: 7'h00};

    // 10*tens + ones using shifts; digits are 0..9 so 7 bits never overflow
    function automatic logic [VALUE_W-1:0] digits_to_bin(
        input logic [DIGIT_W-1:0] tens,
        input logic [DIGIT_W-1:0] ones
    );
        return (VALUE_W'(tens) << 3) + (VALUE_W'(tens) << 1) + VALUE_W'(ones);
    endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational 7-segment glyph to decimal digit decoder.
// Macro SEG_ALT_GLYPH_EN: also accept 7d as 6 and 6f as 9.
module seg_glyph_dec
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0]   glyph_i,
    output logic [DIGIT_W-1:0] digit_c_o,
    output logic               legal_c_o
);

    // Map a glyph to its digit; unknown glyphs are flagged illegal
    always_comb begin
        digit_c_o = '0;
        legal_c_o = 1'b1;
        case (glyph_i)
            GLYPH_0: digit_c_o = 4'd0;
            GLYPH_1: digit_c_o = 4'd1;
            GLYPH_2: digit_c_o = 4'd2;
            GLYPH_3: digit_c_o = 4'd3;
            GLYPH_4: digit_c_o = 4'd4;
            GLYPH_5: digit_c_o = 4'd5;
            GLYPH_6: digit_c_o = 4'd6;
            GLYPH_7: digit_c_o = 4'd7;
            GLYPH_8: digit_c_o = 4'd8;
            GLYPH_9: digit_c_o = 4'd9;
`ifdef SEG_ALT_GLYPH_EN
            GLYPH_ALT_6: digit_c_o = 4'd6;
            GLYPH_ALT_9: digit_c_o = 4'd9;
`endif
            default: legal_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_rx.sv
// Receiver for a multiplexed 2-digit 7-segment display bus: synchronizes the
// scan lines, accepts slots once stable, and assembles tens+ones frames.
// Macro SEG_ALT_GLYPH_EN: enables alternate 6/9 glyphs in the decoder.
module seg_scan_rx
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [SEG_W-1:0]   SEG_C,
    input  logic [SEL_W-1:0]   SEG_SEL,
    output logic [DIGIT_W-1:0] DIGIT_10,
    output logic [DIGIT_W-1:0] DIGIT_1,
    output logic [VALUE_W-1:0] VALUE,
    output logic               VALID,
    output logic               ERR
);

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

    scan_sample_t sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic done_q, done_d;
    logic changed_c, accept_c;

    scan_state_e state_q, state_d;
    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] digit10_q, digit10_d;
    logic [DIGIT_W-1:0] digit1_q, digit1_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic valid_q, valid_d;
    logic err_q, err_d;

    logic [DIGIT_W-1:0] dec_digit_c;
    logic dec_legal_c;
    logic is_tens_c, is_ones_c, is_blank_c;

    // Decode the glyph of the sample being accepted
    seg_glyph_dec u_glyph_dec (
        .glyph_i   (prev_q.seg),
        .digit_c_o (dec_digit_c),
        .legal_c_o (dec_legal_c)
    );

    // Two-flop synchronizer on the scan bus, then one delay for change detection
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1_q <= SAMPLE_RST;
            sync2_q <= SAMPLE_RST;
            prev_q  <= SAMPLE_RST;
        end else begin
            sync1_q <= '{sel: SEG_SEL, seg: SEG_C};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Stability counter: accept once when the count reaches STABLE_CYCLES
    always_comb begin
        cnt_d     = cnt_q;
        done_d    = done_q;
        changed_c = (sync2_q != prev_q);
        accept_c  = (cnt_q == STABLE_CNT) && !done_q;
        if (changed_c) begin
            cnt_d  = CNT_W'(1);
            done_d = 1'b0;
        end else begin
            if (cnt_q < STABLE_CNT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (accept_c) begin
                done_d = 1'b1;
            end
        end
    end

    // Stability counter state
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Frame FSM next state, digit latching and pulse generation
    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        digit10_d = digit10_q;
        digit1_d  = digit1_q;
        value_d   = value_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        is_tens_c  = (prev_q.sel == SEL_TENS);
        is_ones_c  = (prev_q.sel == SEL_ONES);
        is_blank_c = (prev_q.sel == SEL_BLANK);

        // Illegal select codes and illegal glyphs in digit slots are discarded
        if (accept_c && !is_blank_c) begin
            if (!(is_tens_c || is_ones_c) || !dec_legal_c) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            WAIT_TENS: begin
                if (accept_c && is_tens_c && dec_legal_c) begin
                    tens_d  = dec_digit_c;
                    state_d = WAIT_ONES;
                end
            end
            WAIT_ONES: begin
                if (accept_c && is_tens_c && dec_legal_c) begin
                    tens_d = dec_digit_c;
                end else if (accept_c && is_ones_c && dec_legal_c) begin
                    digit10_d = tens_q;
                    digit1_d  = dec_digit_c;
                    value_d   = digits_to_bin(tens_q, dec_digit_c);
                    valid_d   = 1'b1;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                state_d = WAIT_TENS;
            end
            default: begin
                state_d = WAIT_TENS;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= WAIT_TENS;
            tens_q    <= '0;
            digit10_q <= '0;
            digit1_q  <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            digit10_q <= digit10_d;
            digit1_q  <= digit1_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign DIGIT_10 = digit10_q;
    assign DIGIT_1  = digit1_q;
    assign VALUE    = value_q;
    assign VALID    = valid_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_seg_scan_rx.sv
// Directed self-checking bench for seg_scan_rx (STABLE_CYCLES = 4).
module tb_seg_scan_rx;

`ifdef SEG_ALT_GLYPH_EN
    localparam int ALT = 1;
`else
    localparam int ALT = 0;
`endif

    logic       CLK;
    logic       RESET;
    logic [6:0] SEG_C;
    logic [7:0] SEG_SEL;
    logic [3:0] DIGIT_10;
    logic [3:0] DIGIT_1;
    logic [6:0] VALUE;
    logic       VALID;
    logic       ERR;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_n = 0;
    int err_n = 0;
    int both_n = 0;
    int valid_cyc = -1;
    int err_cyc = -1;
    int t0 = 0;
    int exp_val = 0;

    seg_scan_rx #(.STABLE_CYCLES(4)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .SEG_C    (SEG_C),
        .SEG_SEL  (SEG_SEL),
        .DIGIT_10 (DIGIT_10),
        .DIGIT_1  (DIGIT_1),
        .VALUE    (VALUE),
        .VALID    (VALID),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        valid_n   = 0;
        err_n     = 0;
        valid_cyc = -1;
        err_cyc   = -1;
    endtask

    // Hold one scan slot for n rising edges, recording VALID/ERR pulses
    task automatic run(input logic [7:0] sel, input logic [6:0] seg, input int n);
        SEG_SEL = sel;
        SEG_C   = seg;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (VALID === 1'b1) begin
                valid_n++;
                valid_cyc = cyc;
            end
            if (ERR === 1'b1) begin
                err_n++;
                err_cyc = cyc;
            end
            if (VALID === 1'b1 && ERR === 1'b1) both_n++;
        end
        @(negedge CLK);
    endtask

    initial begin
        CLK     = 1'b0;
        RESET   = 1'b0;
        SEG_SEL = 8'hFF;
        SEG_C   = 7'h00;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_digit10", 32'(DIGIT_10), 32'd0);
        check("rst_digit1",  32'(DIGIT_1),  32'd0);
        check("rst_value",   32'(VALUE),    32'd0);
        check("rst_valid",   32'(VALID),    32'd0);
        check("rst_err",     32'(ERR),      32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        run(8'hFF, 7'h00, 8);

        // Basic frame: 3 then 7
        clear_counts();
        run(8'h7F, 7'h4f, 6);
        t0 = cyc;
        run(8'hDF, 7'h07, 6);
        run(8'hFF, 7'h00, 8);
        check("f37_valid_cnt", 32'(valid_n), 32'd1);
        check("f37_err_cnt",   32'(err_n),   32'd0);
        check("f37_latency",   32'(valid_cyc), 32'(t0 + 7));
        check("f37_digit10",   32'(DIGIT_10), 32'd3);
        check("f37_digit1",    32'(DIGIT_1),  32'd7);
        check("f37_value",     32'(VALUE),    32'd37);

        // Tens held one cycle too short: nothing accepted
        clear_counts();
        run(8'h7F, 7'h66, 3);
        run(8'hDF, 7'h3f, 6);
        run(8'hFF, 7'h00, 8);
        check("short_valid_cnt", 32'(valid_n), 32'd0);
        check("short_err_cnt",   32'(err_n),   32'd0);
        check("short_value",     32'(VALUE),   32'd37);

        // Second tens overwrites the first
        clear_counts();
        run(8'h7F, 7'h66, 6);
        run(8'h7F, 7'h6d, 6);
        run(8'hDF, 7'h3f, 6);
        run(8'hFF, 7'h00, 8);
        check("ovw_valid_cnt", 32'(valid_n),  32'd1);
        check("ovw_value",     32'(VALUE),    32'd50);
        check("ovw_digit10",   32'(DIGIT_10), 32'd5);
        check("ovw_digit1",    32'(DIGIT_1),  32'd0);

        // Alternate 6 glyph in a ones slot
        clear_counts();
        run(8'h7F, 7'h06, 6);
        t0 = cyc;
        run(8'hDF, 7'h7d, 6);
        run(8'hFF, 7'h00, 8);
        check("alt6_err_cnt",   32'(err_n),   32'(1 - ALT));
        check("alt6_valid_cnt", 32'(valid_n), 32'(ALT));
`ifndef SEG_ALT_GLYPH_EN
        check("alt6_err_latency", 32'(err_cyc), 32'(t0 + 7));
        check("alt6_value_hold",  32'(VALUE),   32'd50);
`endif
        // Follow-up ones: completes the frame only if still in WAIT_ONES
        clear_counts();
        run(8'hDF, 7'h5b, 6);
        run(8'hFF, 7'h00, 8);
        exp_val = (ALT == 1) ? 16 : 12;
        check("alt6_next_valid", 32'(valid_n), 32'(1 - ALT));
        check("alt6_next_value", 32'(VALUE),   32'(exp_val));

        // Alternate 9 glyph in a tens slot
        clear_counts();
        run(8'h7F, 7'h6f, 6);
        run(8'hFF, 7'h00, 6);
        run(8'hDF, 7'h06, 6);
        run(8'hFF, 7'h00, 8);
        exp_val = (ALT == 1) ? 91 : 12;
        check("alt9_err_cnt",   32'(err_n),   32'(1 - ALT));
        check("alt9_valid_cnt", 32'(valid_n), 32'(ALT));
        check("alt9_value",     32'(VALUE),   32'(exp_val));

        // Illegal select code, then blank with a lit glyph
        clear_counts();
        run(8'b0101_1111, 7'h3f, 6);
        run(8'hFF, 7'h00, 8);
        check("badsel_err_cnt",   32'(err_n),   32'd1);
        check("badsel_valid_cnt", 32'(valid_n), 32'd0);
        check("badsel_value",     32'(VALUE),   32'(exp_val));
        clear_counts();
        run(8'hFF, 7'h3f, 10);
        check("blank_err_cnt",   32'(err_n),   32'd0);
        check("blank_valid_cnt", 32'(valid_n), 32'd0);

        // Reset between tens and ones discards the latched tens
        clear_counts();
        run(8'h7F, 7'h4f, 8);
        RESET   = 1'b0;
        SEG_SEL = 8'hDF;
        SEG_C   = 7'h07;
        #1;
        check("midrst_value",   32'(VALUE),    32'd0);
        check("midrst_digit10", 32'(DIGIT_10), 32'd0);
        check("midrst_digit1",  32'(DIGIT_1),  32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        run(8'hDF, 7'h07, 6);
        run(8'hFF, 7'h00, 8);
        check("midrst_valid_cnt", 32'(valid_n), 32'd0);
        check("midrst_err_cnt",   32'(err_n),   32'd0);
        clear_counts();
        run(8'h7F, 7'h6d, 6);
        run(8'hDF, 7'h07, 6);
        run(8'hFF, 7'h00, 8);
        check("post_valid_cnt", 32'(valid_n),  32'd1);
        check("post_value",     32'(VALUE),    32'd57);
        check("post_digit10",   32'(DIGIT_10), 32'd5);
        check("post_digit1",    32'(DIGIT_1),  32'd7);

        check("valid_err_overlap", 32'(both_n), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
